instruction_fetch_unit: RTL and testbench

//  Fetch stage feeding the 16-bit RISC-V Processor decode stage. Holds the fetch PC, issues
//  in-order requests to instruction memory, buffers returned instructions in a small prefetch

---
 rtl/riscv16_pkg.sv | 7 +
 rtl/ifu_fifo.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv16_pkg.sv
// riscv16_pkg: shared widths, reset PC and fetch FSM state type for the 16-bit core
package riscv16_pkg;
    localparam int XLEN = 16;
    localparam int INSTR_BYTES = 2;
    localparam logic [XLEN-1:0] RESET_PC = 16'h0000;
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} ifu_state_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous prefetch FIFO with flush and occupancy count
//  clk, reset          : clock, synchronous active-high reset
//  flush               : empties the FIFO (wins over push/pop)
//  push, push_data     : write one entry (caller guarantees not full)
//  pop                 : drop head entry (caller guarantees not empty)
//  head, count         : current head entry and occupancy
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) mem[wr_ptr] <= push_data;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC, in-order imem requests, prefetch FIFO to decode
//  clk, reset                        : clock, synchronous active-high reset
//  imem_req_valid/ready/addr         : request channel to instruction memory
//  imem_rsp_valid/data               : in-order responses, no backpressure
//  redirect_valid/pc                 : taken branch/jump from execute
//  if_valid/ready/instr/pc           : FIFO head to decode
//  perf_fetched/perf_bubble          : saturating counters, present only with IFU_PERF_CNT_EN
module instruction_fetch_unit #(
    parameter int XLEN = riscv16_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv16_pkg::RESET_PC,
    parameter int FIFO_DEPTH = 2
)(
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubble
`endif
);
    import riscv16_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);
    ifu_state_t state;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count, remaining;
    logic [2*XLEN-1:0] head;
    logic req_fire, rsp_fire, push, pop;
    assign target = {redirect_pc[XLEN-1:1], 1'b0};
    // outstanding plus buffered never exceeds depth, so the FIFO cannot overflow
    assign imem_req_valid = state == S_FETCH && fifo_count + outstanding < DEPTH_C && !redirect_valid;
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && outstanding != '0;
    // responses still owed after this cycle; on redirect these become stale drops
    assign remaining = outstanding - CW'(rsp_fire);
    assign push = rsp_fire && state == S_FETCH && !redirect_valid;
    assign if_valid = fifo_count != '0;
    assign pop = if_valid && if_ready;
    assign {if_pc, if_instr} = if_valid ? head : '0;
    ifu_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(redirect_valid),
        .push(push),
        .push_data({rsp_pc, imem_rsp_data}),
        .pop(pop),
        .head(head),
        .count(fifo_count)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BOOT;
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            state <= remaining != '0 ? S_DRAIN : S_FETCH;
            fetch_pc <= target;
            rsp_pc <= target;
            outstanding <= remaining;
            drop_cnt <= remaining;
        end else begin
            state <= state == S_BOOT ? S_FETCH :
                     (state == S_DRAIN && rsp_fire && drop_cnt == CW'(1)) ? S_FETCH : state;
            drop_cnt <= drop_cnt - CW'(state == S_DRAIN && rsp_fire);
            outstanding <= remaining + CW'(req_fire);
            fetch_pc <= req_fire ? fetch_pc + STEP : fetch_pc;
            rsp_pc <= push ? rsp_pc + STEP : rsp_pc;
        end
    end
`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubble <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop && perf_fetched != '1);
            perf_bubble <= perf_bubble + 32'(if_ready && !if_valid && state != S_BOOT && perf_bubble != '1);
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized bench with an address-stream reference model
module tb_instruction_fetch_unit;
    logic clk = 0;
    logic reset = 1, imem_req_valid, imem_req_ready = 1, imem_rsp_valid = 0;
    logic redirect_valid = 0, if_valid, if_ready = 0;
    logic [15:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0, if_instr, if_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubble;
`endif
    instruction_fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_pc(if_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_bubble(perf_bubble)
`endif
    );
    always #5 clk = ~clk;

    typedef struct {logic [15:0] addr; int due;} mreq_t;
    mreq_t memq[$];
    logic [15:0] req_log[$], pop_log[$];
    int cyc = 0, checks = 0, passed = 0, lat = 1, last_due = 0, pops = 0, bubbles = 0;
    logic nx_reset = 1, nx_redirect = 0, nx_ready = 0, nx_req_ready = 1;
    logic [15:0] nx_tgt = 0, exp_req = 0, exp_pop = 0;
    logic fired, popped, rsp_now, booting = 1;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // one clock: apply inputs, drive memory, score fires/pops against the address streams
    task automatic step();
        @(negedge clk);
        reset = nx_reset;
        redirect_valid = nx_redirect;
        redirect_pc = nx_tgt;
        if_ready = nx_ready;
        imem_req_ready = nx_req_ready;
        rsp_now = !reset && memq.size() > 0 && memq[0].due == cyc;
        imem_rsp_valid = rsp_now;
        imem_rsp_data = rsp_now ? memfn(memq[0].addr) : 16'($urandom);
        if (rsp_now) void'(memq.pop_front());
        #1;
        fired = imem_req_valid && imem_req_ready;
        popped = if_valid && if_ready;
        if (reset) begin
            memq.delete();
            exp_req = 16'h0000;
            exp_pop = 16'h0000;
            booting = 1;
            last_due = 0;
            pops = 0;
            bubbles = 0;
        end else begin
            if (fired) begin
                checks++;
                if (imem_req_addr !== exp_req) $display("FAIL req_addr cyc %0d got %h want %h", cyc, imem_req_addr, exp_req);
                else passed++;
                req_log.push_back(imem_req_addr);
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                memq.push_back('{imem_req_addr, last_due});
                exp_req += 16'd2;
            end
            if (popped) begin
                checks++;
                if (if_pc !== exp_pop || if_instr !== memfn(exp_pop))
                    $display("FAIL pop cyc %0d got pc %h instr %h want pc %h instr %h", cyc, if_pc, if_instr, exp_pop, memfn(exp_pop));
                else passed++;
                pop_log.push_back(if_pc);
                exp_pop += 16'd2;
                pops++;
            end
            if (if_ready && !if_valid && !booting) bubbles++;
            booting = 0;
            if (redirect_valid) begin
                exp_req = {redirect_pc[15:1], 1'b0};
                exp_pop = {redirect_pc[15:1], 1'b0};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        nx_reset = 1;
        step();
        step();
        nx_reset = 0;
    endtask

    task automatic test_reset();
        nx_ready = 1;
        do_reset();
        repeat (8) step();
        nx_reset = 1;
        step();
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 16'h0000)
            $display("FAIL reset_req got valid %b addr %h want 0 0000", imem_req_valid, imem_req_addr);
        else passed++;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 16'h0 || if_pc !== 16'h0)
            $display("FAIL reset_if got valid %b instr %h pc %h want 0 0000 0000", if_valid, if_instr, if_pc);
        else passed++;
    endtask

    task automatic test_basic();
        int n = 0;
        lat = 1;
        nx_ready = 1;
        nx_reset = 0;
        while (!if_valid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (n !== 3) $display("FAIL first_valid_latency got %0d want 3", n);
        else passed++;
        pops = 0;
        repeat (30) step();
        checks++;
        if (pops < 15) $display("FAIL basic_throughput got %0d pops want >=15", pops);
        else passed++;
    endtask

    task automatic test_backpressure();
        nx_ready = 0;
        do_reset();
        req_log.delete();
        pop_log.delete();
        repeat (10) step();
        checks++;
        if (req_log.size() != 2 || imem_req_valid !== 1'b0)
            $display("FAIL stall_requests got %0d reqs valid %b want 2 0", req_log.size(), imem_req_valid);
        else passed++;
        nx_ready = 1;
        repeat (6) step();
        checks++;
        if (pop_log.size() < 2) $display("FAIL stall_release got %0d pops want >=2", pop_log.size());
        else if (pop_log[0] !== 16'h0000 || pop_log[1] !== 16'h0002)
            $display("FAIL stall_order got %h %h want 0000 0002", pop_log[0], pop_log[1]);
        else passed++;
    endtask

    task automatic test_drain();
        int n = 0, drops = 0;
        nx_ready = 1;
        lat = 3;
        do_reset();
        while (!(memq.size() == 2 && memq[0].due != cyc) && n < 20) begin
            step();
            n++;
        end
        nx_redirect = 1;
        nx_tgt = 16'h0100;
        req_log.delete();
        pop_log.delete();
        step();
        nx_redirect = 0;
        n = 0;
        while (req_log.size() == 0 && n < 20) begin
            step();
            if (rsp_now && !fired) drops++;
            n++;
        end
        checks++;
        if (drops != 2 || req_log.size() == 0) $display("FAIL drain_drops got %0d drops %0d reqs want 2 >=1", drops, req_log.size());
        else passed++;
        n = 0;
        while (pop_log.size() == 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (pop_log.size() == 0) $display("FAIL drain_first_pop got none want 0100");
        else if (pop_log[0] !== 16'h0100) $display("FAIL drain_first_pop got %h want 0100", pop_log[0]);
        else passed++;
    endtask

    task automatic test_collide();
        int n = 0;
        lat = 1;
        while (!(if_valid && memq.size() > 0 && memq[0].due == cyc) && n < 40) begin
            nx_ready = 1'($urandom);
            step();
            n++;
        end
        nx_ready = 1;
        nx_redirect = 1;
        nx_tgt = 16'h2468;
        step();
        nx_redirect = 0;
        checks++;
        if (!(popped && rsp_now)) $display("FAIL collide_setup got pop %b rsp %b want 1 1", popped, rsp_now);
        else passed++;
        checks++;
        if (if_valid !== 1'b0) $display("FAIL collide_flush got if_valid %b want 0", if_valid);
        else passed++;
        repeat (10) step();
    endtask

    task automatic test_wrap();
        int n = 0;
        lat = 2;
        nx_ready = 1;
        req_log.delete();
        nx_redirect = 1;
        nx_tgt = 16'hFFFD;
        step();
        nx_redirect = 0;
        while (req_log.size() < 3 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (req_log.size() < 3) $display("FAIL wrap_reqs got %0d reqs want 3", req_log.size());
        else if (req_log[0] !== 16'hFFFC || req_log[1] !== 16'hFFFE || req_log[2] !== 16'h0000)
            $display("FAIL wrap_addrs got %h %h %h want fffc fffe 0000", req_log[0], req_log[1], req_log[2]);
        else passed++;
        repeat (10) step();
    endtask

    task automatic test_random();
        pops = 0;
        for (int i = 0; i < 400; i++) begin
            nx_ready = ($urandom % 4) != 0;
            nx_req_ready = ($urandom % 3) != 0;
            nx_redirect = ($urandom % 20) == 0;
            nx_tgt = 16'($urandom);
            if (($urandom % 50) == 0) lat = $urandom_range(1, 4);
            step();
        end
        nx_redirect = 0;
        nx_req_ready = 1;
        nx_ready = 1;
        checks++;
        if (pops < 30) $display("FAIL random_progress got %0d pops want >=30", pops);
        else passed++;
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf();
        int n = 0;
        lat = 1;
        do_reset();
        while (pops < 20 && n < 300) begin
            nx_ready = ($urandom % 4) != 0;
            step();
            n++;
        end
        nx_ready = 0;
        checks++;
        if (perf_fetched !== 32'(pops)) $display("FAIL perf_fetched got %0d want %0d", perf_fetched, pops);
        else passed++;
        checks++;
        if (perf_bubble !== 32'(bubbles)) $display("FAIL perf_bubble got %0d want %0d", perf_bubble, bubbles);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drain();
        test_collide();
        test_wrap();
        test_random();
`ifdef IFU_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
